imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Writer side of the 256x32 instruction memory. Receives a byte stream over a
//  valid/ready handshake and packs it little-endian into 32-bit words.
//  Each word is written through a single write port (A/WD/WE) at consecutive word addresses.
//  BUSY holds the core off while the program image is loaded, before the memory is read as ROM.
// PARAMETERS
//  DEPTH   256  memory depth in words; LEN above DEPTH is clamped to DEPTH
//  ADDR_W  8    word-counter width, $clog2(DEPTH)
// PORTS
//  CLK         in   1      clock, all state changes on rising edge
//  RST         in   1      asynchronous, active-high reset
//  START       in   1      1-cycle pulse that begins a load; ignored while BUSY=1
//  LEN         in   ADDR_W+1  number of words to load, sampled when START is accepted
//  BYTE_VALID  in   1      BYTE_DATA is valid
//  BYTE_DATA   in   8      next byte of the image, first byte = bits [7:0]
//  BYTE_READY  out  1      loader accepts a byte this cycle
//  WE          out  1      memory write enable, 1 cycle per word
//  A           out  32     word address, word counter zero-extended
//  WD          out  32     assembled write data
//  BUSY        out  1      load in progress
//  DONE        out  1      load finished; sticky until the next START
//  ERR         out  1      checksum mismatch; sticky until the next START
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; byte and word counters 0; assembly register 0.
//  Byte transfer happens on BYTE_VALID & BYTE_READY; when VALID=0 nothing changes.
//  FSM:
//   IDLE:  READY=0, BUSY=0.
//          START: latch min(LEN,DEPTH), clear counters, DONE=0, ERR=0.
//          If the latched LEN=0 go to FIN, else go to RECV.
//   RECV:  READY=1, BUSY=1.
//          The k-th accepted byte (k=0..3) goes to WD bits [8k+7:8k].
//          Accepting byte 3 moves to WRITE.
//   WRITE: READY=0, WE=1, A=word_cnt, WD=assembled word.
//          Next cycle: word_cnt+1, byte_cnt=0.
//          If word_cnt+1==LEN go to CHECK (macro defined) or FIN; else go to RECV.
//   CHECK: READY=1; receive 4 checksum bytes the same way, then go to FIN.
//   FIN:   DONE=1, BUSY=0, READY=0.
//          START begins a new load (same actions as from IDLE).
//  Timing:
//   - WE rises the cycle after the 4th byte handshake.
//   - Peak rate is 1 word per 5 cycles; WE is never high two cycles in a row.
//   - WE, A and WD are registered outputs; A and WD hold their values when WE=0.
//   - DONE rises the cycle after the last WRITE, or after the last checksum byte.
//  Boundaries:
//   - START while BUSY=1 is ignored, with no effect on counters or LEN.
//   - LEN=DEPTH writes addresses 0..DEPTH-1; word_cnt never wraps past DEPTH-1.
//   - RST during a load returns to IDLE at once. Words already written stay in memory.
//     The partial word is discarded.
//   - BYTE_DATA is ignored whenever READY=0.
// CONFIGURATION
//  Macro IMEM_LOADER_CHECKSUM_EN:
//   Defined: keep a running sum of all written words, 32-bit, wrap-around.
//    After the last word, the CHECK state takes one more little-endian word.
//    ERR=1 at FIN if that word differs from the sum.
//   Undefined: no CHECK state, no adder; ERR tied to 0; WRITE goes straight to FIN.
// TESTING
//  1 Reset: assert RST mid-sim -> WE=0, BYTE_READY=0, BUSY=0, DONE=0, ERR=0, A=0, WD=0.
//  2 LEN=2, bytes 78 56 34 12 EF BE AD DE, VALID held high
//    -> WE at A=0 with WD=0x12345678; WE at A=1 with WD=0xDEADBEEF; then DONE=1, BUSY=0.
//  3 Same stream with VALID=1 only every 3rd cycle -> identical two writes, no extra WE.
//  4 START with LEN=0 -> DONE=1 one cycle later, WE never asserted; START during BUSY -> ignored.
//  5 RST after 2 bytes of a word; then START with LEN=1 and bytes 01 02 03 04
//    -> single WE at A=0 with WD=0x04030201.
//  6 (CHECKSUM_EN) Test 2 plus checksum bytes 67 15 E2 F0 -> ERR=0.
//    Checksum bytes 00 00 00 00 -> ERR=1, DONE=1.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader for the 256x32 instruction memory: packs bytes little-endian and writes whole words.
// Optional checksum word after the image is enabled with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              we_o,
    output logic [31:0]       a_o,
    output logic [31:0]       wd_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_FIN
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d, asm_nxt;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [31:0]       wd_q, wd_d;
    logic [ADDR_W:0]   len_clamped;
    logic              fire;
    logic              last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       sum_q, sum_d;
    logic              err_q, err_d;
`endif

    assign len_clamped = (len_i > DEPTH_W) ? DEPTH_W : len_i;
    assign last_word   = (({1'b0, word_cnt_q} + ONE_W) == len_q);
    assign fire        = byte_valid_i & byte_ready_o;

    // Byte lane for the current byte inside the word being assembled
    always_comb begin
        asm_nxt = asm_q;
        case (byte_cnt_q)
            2'd0:    asm_nxt[7:0]   = byte_data_i;
            2'd1:    asm_nxt[15:8]  = byte_data_i;
            2'd2:    asm_nxt[23:16] = byte_data_i;
            default: asm_nxt[31:24] = byte_data_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        we_d       = 1'b0;
        a_d        = a_q;
        wd_d       = wd_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        err_d      = err_q;
`endif
        byte_ready_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;

        case (state_q)
            S_IDLE, S_FIN: begin
                done_o = (state_q == S_FIN);
                if (start_i) begin
                    len_d      = len_clamped;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    asm_d      = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = '0;
                    err_d      = 1'b0;
`endif
                    state_d    = (len_clamped == '0) ? S_FIN : S_RECV;
                end
            end
            S_RECV: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (fire) begin
                    asm_d      = asm_nxt;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        a_d     = word_cnt_q;
                        wd_d    = asm_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d   = sum_q + asm_nxt;
`endif
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                busy_o     = 1'b1;
                byte_cnt_d = '0;
                // The counter stays at the final address so a full-depth load never wraps
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_FIN;
`endif
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    state_d    = S_RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (fire) begin
                    asm_d      = asm_nxt;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        err_d   = (asm_nxt != sum_q);
                        state_d = S_FIN;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            we_q       <= 1'b0;
            a_q        <= '0;
            wd_q       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            we_q       <= we_d;
            a_q        <= a_d;
            wd_q       <= wd_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            err_q      <= err_d;
`endif
        end
    end

    assign we_o = we_q;
    assign a_o  = {{(32-ADDR_W){1'b0}}, a_q};
    assign wd_o = wd_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
